mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Word-organised RAM that acts as the responding side of the CPU memory interface: it accepts read and write requests and answers each one with a single-cycle acknowledge after a programmable number of wait states.
- It replaces the zero-latency memory model so the multicycle controller can be exercised against slow memory.
- It sits between the CPU address mux (PC or ALU output) and the instruction register / MDR.
- It also flags misaligned and out-of-range accesses.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words stored; valid byte addresses are 0 .. 4*DEPTH_WORDS-1.
- LATENCY, 2, wait-state cycles inserted between request acceptance and acknowledge (0..15).

Ports:
- Clock  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Req  input  1  request valid; initiator holds Address/Wr/DataIn stable while Req=1.
- Wr  input  1  1 = write, 0 = read.
- Address  input  32  byte address.
- DataIn  input  32  write data.
- DataOut  output  32  read data, registered.
- Ack  output  1  one-cycle completion pulse.
- AddrErr  output  1  qualifies Ack: the access was rejected.
- Busy  output  1  high whenever the block is not in IDLE.

Behaviour:
- Reset (Reset=1 at a rising edge): state=IDLE, wait counter=0, DataOut=0, Ack=0, AddrErr=0, Busy=0. Any in-flight access is abandoned; a pending write is not committed. RAM contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If Req=1 at an edge, latch Address, Wr and DataIn, and load counter=LATENCY.
  - Next state is WAIT if LATENCY>0, otherwise RESP.
  - If Req=0, remain in IDLE.
- WAIT: at each edge, if counter==1 go to RESP; otherwise decrement the counter.
- Commit action at the edge entering RESP:
  - Error check first: AddrErr is set if latched Address[1:0]!=0 or Address>=4*DEPTH_WORDS. On error, no RAM write occurs and DataOut is unchanged.
  - Otherwise, a write stores DataIn at word Address[31:2]; DataOut is unchanged.
  - Otherwise, a read loads DataOut with the RAM word at Address[31:2].
- RESP: Ack=1 for exactly this one cycle, then go to IDLE unconditionally. Req is ignored while in RESP.
- Latency: with Req sampled at edge k, Ack is high during the cycle after edge k+1+LATENCY. Throughput is one access per LATENCY+2 cycles.
- AddrErr is driven only during the Ack cycle and is 0 in every other cycle.
- Busy=1 in WAIT and RESP.
- DataOut holds its value until the next successful read, including across writes and errors.
- Req is not sampled in WAIT or RESP, so changes to Req/Address/Wr/DataIn after acceptance have no effect. Dropping Req early does not cancel the access.
- Read-after-write to the same word, issued right after the write's Ack, returns the new data.
- Address bits [31:2] are used directly, with no wrap-around; addresses beyond the range produce AddrErr rather than aliasing.

Test Plan:
- Reset, then with LATENCY=2: write 0xDEADBEEF to address 0x10, with Req asserted at edge 0 → Ack pulses exactly once in the cycle after edge 3, AddrErr=0, DataOut stays 0.
- Read from address 0x10 immediately after the write's Ack → Ack after 4 cycles, DataOut=0xDEADBEEF, held for the following 10 idle cycles.
- Misaligned write of 0x12345678 to 0x13, then read of 0x10 → the first Ack has AddrErr=1; the read returns 0xDEADBEEF (RAM unchanged).
- Read of 0x400 with DEPTH_WORDS=256 → Ack with AddrErr=1, DataOut unchanged. Read of 0x3FC → AddrErr=0.
- Assert Reset during WAIT of a write of 0xCAFEF00D to 0x20 → Ack never pulses, Busy=0 and DataOut=0 after the reset edge; a later read of 0x20 does not return 0xCAFEF00D.
- LATENCY=0 with Req held continuously for two reads of 0x0 and 0x4 → Ack pulses are separated by one idle cycle (period 2 cycles), and each read returns the correct word.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: word-organised RAM answering CPU memory requests with a
// one-cycle Ack after LATENCY wait states. Misaligned and out-of-range
// accesses are rejected and flagged with AddrErr alongside Ack.
//
// Ports:
//   Clock    - system clock, all state changes on the rising edge
//   Reset    - synchronous active-high reset (RAM contents are kept)
//   Req      - request valid; Address/Wr/DataIn sampled only in IDLE
//   Wr       - 1 = write, 0 = read
//   Address  - byte address
//   DataIn   - write data
//   DataOut  - registered read data, held until the next successful read
//   Ack      - one-cycle completion pulse
//   AddrErr  - valid with Ack: the access was rejected
//   Busy     - high while in WAIT or RESP
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Req,
  input  logic        Wr,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        Ack,
  output logic        AddrErr,
  output logic        Busy
);

  localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] BYTE_LIMIT = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  LAT_INIT   = 4'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        wr_q;
  logic        err_q;
  logic [31:0] dout_q;
  logic        ack_q;
  logic        aerr_q;
  logic        busy_q;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic             enter_resp_c;
  logic [31:0]      acc_addr_c;
  logic [31:0]      acc_data_c;
  logic             acc_wr_c;
  logic             acc_err_c;
  logic [IDX_W-1:0] acc_idx_c;

  // Access being committed this edge: live inputs when LATENCY=0 commits at
  // the accepting edge, otherwise the values latched at acceptance.
  always_comb begin
    enter_resp_c = 1'b0;
    acc_addr_c   = addr_q;
    acc_data_c   = wdata_q;
    acc_wr_c     = wr_q;
    if (state_q == S_IDLE) begin
      acc_addr_c   = Address;
      acc_data_c   = DataIn;
      acc_wr_c     = Wr;
      enter_resp_c = Req && (LATENCY == 0);
    end else if (state_q == S_WAIT) begin
      enter_resp_c = (cnt_q == 4'd1);
    end
    acc_err_c = (acc_addr_c[1:0] != 2'b00) || (acc_addr_c >= BYTE_LIMIT);
    acc_idx_c = acc_addr_c[IDX_W+1:2];
  end

  // RAM array: never reset; a write aborted by Reset is not committed.
  always_ff @(posedge Clock) begin
    if (!Reset && enter_resp_c && acc_wr_c && !acc_err_c) begin
      mem_q[acc_idx_c] <= acc_data_c;
    end
  end

  // Control FSM. Ack/AddrErr are registered from the RESP state, so the pulse
  // appears in the cycle after RESP and the next request is taken one cycle
  // later, giving a throughput of LATENCY+2 cycles per access.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= '0;
      ack_q   <= 1'b0;
      aerr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ack_q  <= (state_q == S_RESP);
      aerr_q <= (state_q == S_RESP) && err_q;

      case (state_q)
        S_IDLE: begin
          if (Req) begin
            addr_q  <= Address;
            wr_q    <= Wr;
            wdata_q <= DataIn;
            cnt_q   <= LAT_INIT;
            busy_q  <= 1'b1;
            state_q <= (LATENCY == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd1) begin
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      // Commit: errors leave DataOut alone, only successful reads update it.
      if (enter_resp_c) begin
        err_q <= acc_err_c;
        if (!acc_err_c && !acc_wr_c) begin
          dout_q <= mem_q[acc_idx_c];
        end
      end
    end
  end

  assign DataOut = dout_q;
  assign Ack     = ack_q;
  assign AddrErr = aerr_q;
  assign Busy    = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (LATENCY=2 and LATENCY=0) driven
// with directed transactions. A timestamp/array model predicts Ack, AddrErr,
// Busy and DataOut every cycle; directed steps add literal expectations.
module tb_mem_responder;

  localparam int unsigned DEPTH = 256;

  logic        Clock = 1'b0;
  logic [1:0]  rst;
  logic [1:0]  req;
  logic [1:0]  wr;
  logic [31:0] addr [2];
  logic [31:0] din  [2];
  logic [31:0] dout [2];
  logic [1:0]  ack;
  logic [1:0]  aerr;
  logic [1:0]  busy;

  always #5 Clock = ~Clock;

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut_l2 (
    .Clock(Clock), .Reset(rst[0]), .Req(req[0]), .Wr(wr[0]),
    .Address(addr[0]), .DataIn(din[0]), .DataOut(dout[0]),
    .Ack(ack[0]), .AddrErr(aerr[0]), .Busy(busy[0]));

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dut_l0 (
    .Clock(Clock), .Reset(rst[1]), .Req(req[1]), .Wr(wr[1]),
    .Address(addr[1]), .DataIn(din[1]), .DataOut(dout[1]),
    .Ack(ack[1]), .AddrErr(aerr[1]), .Busy(busy[1]));

  int npass  = 0;
  int ntotal = 0;
  bit checking = 0;
  longint ecnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, ecnt);
  endtask

  // ---------------- behavioural model ----------------
  // An access accepted at edge k is busy for cycles k..k+L, commits at edge
  // k+L, and acknowledges in cycle k+L+1; no request is taken at that edge.
  bit          m_active [2];
  longint      m_k      [2];
  bit          m_wr     [2];
  logic [31:0] m_addr   [2];
  logic [31:0] m_din    [2];
  bit          m_err    [2];
  logic [31:0] m_dout   [2];
  bit          m_known  [2];
  bit          e_ack    [2];
  bit          e_aerr   [2];
  bit          e_busy   [2];
  logic [31:0] m_mem [int unsigned];

  function automatic longint lat(input int d);
    return (d == 0) ? 64'd2 : 64'd0;
  endfunction

  task automatic model_step(input int d);
    int unsigned key;
    e_ack[d]  = 1'b0;
    e_aerr[d] = 1'b0;
    if (rst[d]) begin
      m_active[d] = 1'b0;
      m_dout[d]   = '0;
      m_known[d]  = 1'b1;
    end else begin
      if (!m_active[d] && req[d]) begin
        m_active[d] = 1'b1;
        m_k[d]      = ecnt;
        m_wr[d]     = wr[d];
        m_addr[d]   = addr[d];
        m_din[d]    = din[d];
      end else if (m_active[d] && ecnt == m_k[d] + lat(d) + 1) begin
        e_ack[d]    = 1'b1;
        e_aerr[d]   = m_err[d];
        m_active[d] = 1'b0;
      end
      if (m_active[d] && ecnt == m_k[d] + lat(d)) begin
        m_err[d] = (m_addr[d] % 4 != 0) || (m_addr[d] >= 4 * DEPTH);
        key = 32'(d) * 1024 + m_addr[d] / 4;
        if (!m_err[d]) begin
          if (m_wr[d]) m_mem[key] = m_din[d];
          else if (m_mem.exists(key)) begin
            m_dout[d]  = m_mem[key];
            m_known[d] = 1'b1;
          end else m_known[d] = 1'b0;
        end
      end
    end
    e_busy[d] = m_active[d];
  endtask

  always @(posedge Clock) begin
    ecnt++;
    for (int d = 0; d < 2; d++) model_step(d);
  end

  always @(negedge Clock) begin
    if (checking) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("model_ack%0d", d), 32'(ack[d]), 32'(e_ack[d]));
        chk($sformatf("model_aerr%0d", d), 32'(aerr[d]), 32'(e_aerr[d]));
        chk($sformatf("model_busy%0d", d), 32'(busy[d]), 32'(e_busy[d]));
        if (m_known[d]) chk($sformatf("model_dout%0d", d), dout[d], m_dout[d]);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  // Called at a negedge; Req is presented for one edge, then inputs are
  // scrambled to show they are ignored after acceptance.
  task automatic xact(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                      output longint k, output longint ka, output bit ae, output logic [31:0] dq);
    req[d] = 1'b1; wr[d] = w; addr[d] = a; din[d] = wd;
    @(negedge Clock);
    k = ecnt;
    req[d] = 1'b0; wr[d] = ~w; addr[d] = ~a; din[d] = ~wd;
    ka = -1; ae = 1'b0; dq = '0;
    for (int i = 0; i < 40; i++) begin
      if (ack[d]) begin
        ka = ecnt; ae = aerr[d]; dq = dout[d];
        break;
      end
      @(negedge Clock);
    end
    if (ka < 0) begin
      ntotal++;
      $display("FAIL ack_timeout%0d: got no Ack expected Ack within 40 cycles", d);
    end
  endtask

  initial begin
    longint k, ka, ka_prev, k0;
    bit ae;
    logic [31:0] dq;
    int acks;

    #200000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    longint k, ka, ka_prev, k0;
    bit ae;
    logic [31:0] dq;
    int acks;

    rst = 2'b11; req = '0; wr = '0;
    addr[0] = '0; addr[1] = '0; din[0] = '0; din[1] = '0;
    repeat (2) @(negedge Clock);
    rst = 2'b00;
    checking = 1'b1;
    chk("reset_busy", 32'(busy[0]), 32'd0);
    chk("reset_ack", 32'(ack[0]), 32'd0);
    chk("reset_aerr", 32'(aerr[0]), 32'd0);
    chk("reset_dout", dout[0], 32'h0);

    // Write DEADBEEF @0x10: Ack in cycle after edge k+3
    xact(0, 1'b1, 32'h10, 32'hDEADBEEF, k, ka, ae, dq);
    chk("wr_latency", 32'(ka - k), 32'd3);
    chk("wr_aerr", 32'(ae), 32'd0);
    chk("wr_dout", dq, 32'h0);

    // Immediate read of 0x10: Ack 4 cycles after the write's Ack
    ka_prev = ka;
    xact(0, 1'b0, 32'h10, 32'h0, k, ka, ae, dq);
    chk("rd_ack_spacing", 32'(ka - ka_prev), 32'd4);
    chk("rd_dout", dq, 32'hDEADBEEF);
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      chk("rd_dout_hold", dout[0], 32'hDEADBEEF);
    end

    // Misaligned write, then read back the untouched word
    xact(0, 1'b1, 32'h13, 32'h12345678, k, ka, ae, dq);
    chk("misalign_aerr", 32'(ae), 32'd1);
    xact(0, 1'b0, 32'h10, 32'h0, k, ka, ae, dq);
    chk("misalign_rd_aerr", 32'(ae), 32'd0);
    chk("misalign_rd_dout", dq, 32'hDEADBEEF);

    // Range boundary
    xact(0, 1'b0, 32'h400, 32'h0, k, ka, ae, dq);
    chk("oob_aerr", 32'(ae), 32'd1);
    chk("oob_dout", dq, 32'hDEADBEEF);
    xact(0, 1'b1, 32'h3FC, 32'h0BADC0DE, k, ka, ae, dq);
    chk("top_wr_aerr", 32'(ae), 32'd0);
    xact(0, 1'b0, 32'h3FC, 32'h0, k, ka, ae, dq);
    chk("top_rd_aerr", 32'(ae), 32'd0);
    chk("top_rd_dout", dq, 32'h0BADC0DE);

    // Reset during WAIT abandons a pending write
    xact(0, 1'b1, 32'h20, 32'h11111111, k, ka, ae, dq);
    req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h20; din[0] = 32'hCAFEF00D;
    @(negedge Clock);
    req[0] = 1'b0;
    chk("abort_busy_wait", 32'(busy[0]), 32'd1);
    @(negedge Clock);
    rst[0] = 1'b1;
    @(negedge Clock);
    rst[0] = 1'b0;
    chk("abort_busy", 32'(busy[0]), 32'd0);
    chk("abort_dout", dout[0], 32'h0);
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clock);
      if (ack[0]) acks++;
    end
    chk("abort_no_ack", 32'(acks), 32'd0);
    xact(0, 1'b0, 32'h20, 32'h0, k, ka, ae, dq);
    chk("abort_rd_dout", dq, 32'h11111111);

    // LATENCY=0 instance: preload two words
    xact(1, 1'b1, 32'h0, 32'hA5A50000, k, ka, ae, dq);
    chk("l0_wr_latency", 32'(ka - k), 32'd1);
    xact(1, 1'b1, 32'h4, 32'h00005A5A, k, ka, ae, dq);

    // Req held across two reads: Acks in cycles k0+1 and k0+3
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h0;
    @(negedge Clock);
    k0 = ecnt;
    addr[1] = 32'h4;
    @(negedge Clock);
    chk("l0_ack1", 32'(ack[1]), 32'd1);
    chk("l0_dout1", dout[1], 32'hA5A50000);
    @(negedge Clock);
    req[1] = 1'b0;
    chk("l0_gap", 32'(ack[1]), 32'd0);
    @(negedge Clock);
    chk("l0_ack2", 32'(ack[1]), 32'd1);
    chk("l0_ack2_edge", 32'(ecnt - k0), 32'd3);
    chk("l0_dout2", dout[1], 32'h00005A5A);

    repeat (4) @(negedge Clock);
    checking = 1'b0;
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
